// File: rtl/frame_sync_pkg.sv
// Shared encodings for frame_sync_ctrl: FSM state codes, default game-register
// indices and external_inputs field offsets.
package frame_sync_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_WR = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    localparam logic [4:0] DEF_BALL_REG  = 5'd1;
    localparam logic [4:0] DEF_LPAD_REG  = 5'd2;
    localparam logic [4:0] DEF_RPAD_REG  = 5'd3;
    localparam logic [4:0] DEF_NOTE1_REG = 5'd4;
    localparam logic [4:0] DEF_NOTE2_REG = 5'd5;
    localparam logic [4:0] DEF_NOTE3_REG = 5'd6;
    localparam logic [4:0] DEF_ACK_REG   = 5'd7;

    localparam int unsigned NUM_BTN     = 6;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned BTN_LSB     = 0;
    localparam int unsigned CNT_LSB     = 16;
    localparam int unsigned ACK_BIT     = 31;

    // True when idx addresses any of the six frame-snapshotted registers.
    function automatic logic is_game_reg(
        input logic [4:0] idx,
        input logic [4:0] r0,
        input logic [4:0] r1,
        input logic [4:0] r2,
        input logic [4:0] r3,
        input logic [4:0] r4,
        input logic [4:0] r5
    );
        return (idx == r0) || (idx == r1) || (idx == r2) ||
               (idx == r3) || (idx == r4) || (idx == r5);
    endfunction

endpackage

// File: rtl/frame_sync_ctrl_debounce_bit.sv
// One guitar button: 2-flop synchronizer followed by a stability counter that
// only accepts a new level after DB_CYCLES consecutive matching samples.
module debounce_bit #(
    parameter int unsigned DB_W      = 18,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Per-frame snapshot scheduler between regfile game registers and the VGA path,
// plus debounced guitar buttons and frame counter. Optional macro: FRAME_ACK_EN.
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int unsigned DB_W      = 18,
    parameter int unsigned DB_CYCLES = 250000,
    parameter int unsigned WAIT_MAX  = 8,
    parameter logic [4:0]  BALL_REG  = DEF_BALL_REG,
    parameter logic [4:0]  LPAD_REG  = DEF_LPAD_REG,
    parameter logic [4:0]  RPAD_REG  = DEF_RPAD_REG,
    parameter logic [4:0]  NOTE1_REG = DEF_NOTE1_REG,
    parameter logic [4:0]  NOTE2_REG = DEF_NOTE2_REG,
    parameter logic [4:0]  NOTE3_REG = DEF_NOTE3_REG,
    parameter logic [4:0]  ACK_REG   = DEF_ACK_REG
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vga_vs,
    input  logic [5:0]  guitar_raw,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    input  logic [31:0] ball_in,
    input  logic [31:0] left_paddle_in,
    input  logic [31:0] right_paddle_in,
    input  logic [31:0] notes1_in,
    input  logic [31:0] notes2_in,
    input  logic [31:0] notes3_in,
    output logic [31:0] ball_out,
    output logic [31:0] left_paddle_out,
    output logic [31:0] right_paddle_out,
    output logic [31:0] notes1_out,
    output logic [31:0] notes2_out,
    output logic [31:0] notes3_out,
    output logic [31:0] external_inputs,
    output logic        frame_tick,
    output logic        busy,
    output logic [7:0]  overrun_count
);

    localparam int unsigned     WC_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    logic                   r_vs_sync1;
    logic                   r_vs_sync2;
    logic                   r_vs_hist;
    logic                   w_vs_fall;
    logic                   w_conflict;
    logic                   w_wait_last;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic                   r_pending;
    logic [WC_W-1:0]        r_wait_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic [FRAME_CNT_W-1:0] w_frame_count_next;
    logic [7:0]             r_overrun;
    logic                   r_tick;

    logic [31:0]            r_ball;
    logic [31:0]            r_lpad;
    logic [31:0]            r_rpad;
    logic [31:0]            r_note1;
    logic [31:0]            r_note2;
    logic [31:0]            r_note3;

    logic [NUM_BTN-1:0]     w_btn;
    logic [31:0]            r_ext;
    logic [31:0]            w_ext_next;
    logic                   w_unused_data;

    // Synchronizer and history preset to 1 so reset release never looks like a falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vs_sync1 <= 1'b1;
            r_vs_sync2 <= 1'b1;
            r_vs_hist  <= 1'b1;
        end else begin
            r_vs_sync1 <= vga_vs;
            r_vs_sync2 <= r_vs_sync1;
            r_vs_hist  <= r_vs_sync2;
        end
    end

    assign w_vs_fall   = r_vs_hist & ~r_vs_sync2;
    assign w_conflict  = ctrl_writeEnable &&
                         is_game_reg(ctrl_writeReg, BALL_REG, LPAD_REG, RPAD_REG,
                                     NOTE1_REG, NOTE2_REG, NOTE3_REG);
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_vs_fall || r_pending) w_state_next = ST_WAIT_WR;
            ST_WAIT_WR: if (!w_conflict || w_wait_last) w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_PUBLISH;
            ST_PUBLISH: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    assign w_frame_count_next = (r_state == ST_PUBLISH) ? r_frame_count + FRAME_CNT_W'(1)
                                                        : r_frame_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pending     <= 1'b0;
            r_wait_cnt    <= '0;
            r_frame_count <= '0;
            r_overrun     <= '0;
            r_tick        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_frame_count <= w_frame_count_next;
            r_tick        <= (r_state == ST_CAPTURE);

            // One vsync may queue behind the current service; any further ones are lost.
            if (r_state == ST_IDLE) begin
                r_pending <= 1'b0;
            end else if (w_vs_fall) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_overrun != 8'hFF) begin
                    r_overrun <= r_overrun + 8'd1;
                end
            end

            if (r_state == ST_IDLE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT_WR && w_conflict && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ball  <= '0;
            r_lpad  <= '0;
            r_rpad  <= '0;
            r_note1 <= '0;
            r_note2 <= '0;
            r_note3 <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_ball  <= ball_in;
            r_lpad  <= left_paddle_in;
            r_rpad  <= right_paddle_in;
            r_note1 <= notes1_in;
            r_note2 <= notes2_in;
            r_note3 <= notes3_in;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        debounce_bit #(
            .DB_W      (DB_W),
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .i_clk   (clock),
            .i_rst   (reset),
            .i_raw   (guitar_raw[g]),
            .o_level (w_btn[g])
        );
    end

`ifdef FRAME_ACK_EN
    logic r_unacked;
    logic w_ack_wr;
    logic w_unacked_next;

    assign w_ack_wr       = ctrl_writeEnable && (ctrl_writeReg == ACK_REG) && data_writeReg[0];
    assign w_unacked_next = (r_state == ST_PUBLISH) ? 1'b1 :
                            (w_ack_wr ? 1'b0 : r_unacked);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_unacked <= 1'b0;
        end else begin
            r_unacked <= w_unacked_next;
        end
    end

    always_comb begin
        w_ext_next                        = '0;
        w_ext_next[BTN_LSB +: NUM_BTN]    = w_btn;
        w_ext_next[CNT_LSB +: FRAME_CNT_W-1] = w_frame_count_next[FRAME_CNT_W-2:0];
        w_ext_next[ACK_BIT]               = w_unacked_next;
    end
`else
    always_comb begin
        w_ext_next                        = '0;
        w_ext_next[BTN_LSB +: NUM_BTN]    = w_btn;
        w_ext_next[CNT_LSB +: FRAME_CNT_W] = w_frame_count_next;
    end
`endif

    // Next-state values feed the word so the count field moves on the same edge as the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ext <= '0;
        end else begin
            r_ext <= w_ext_next;
        end
    end

    assign w_unused_data = ^{data_writeReg, ACK_REG};

    assign ball_out         = r_ball;
    assign left_paddle_out  = r_lpad;
    assign right_paddle_out = r_rpad;
    assign notes1_out       = r_note1;
    assign notes2_out       = r_note2;
    assign notes3_out       = r_note3;
    assign external_inputs  = r_ext;
    assign frame_tick       = r_tick;
    assign busy             = (r_state != ST_IDLE);
    assign overrun_count    = r_overrun;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Scoreboard bench for frame_sync_ctrl: stimulus pushes expected frames,
// a monitor pops and checks them on every frame_tick.
module tb_frame_sync_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        vga_vs;
    logic [5:0]  guitar_raw;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] ball_in, left_paddle_in, right_paddle_in;
    logic [31:0] notes1_in, notes2_in, notes3_in;
    logic [31:0] ball_out, left_paddle_out, right_paddle_out;
    logic [31:0] notes1_out, notes2_out, notes3_out;
    logic [31:0] external_inputs;
    logic        frame_tick;
    logic        busy;
    logic [7:0]  overrun_count;

    typedef struct {
        logic [31:0] ball, lpad, rpad, n1, n2, n3;
        int unsigned tick_cyc;
        logic [15:0] count;
    } sb_t;

    sb_t         exp_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_frames = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    frame_sync_ctrl #(
        .DB_CYCLES (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .vga_vs           (vga_vs),
        .guitar_raw       (guitar_raw),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ball_in          (ball_in),
        .left_paddle_in   (left_paddle_in),
        .right_paddle_in  (right_paddle_in),
        .notes1_in        (notes1_in),
        .notes2_in        (notes2_in),
        .notes3_in        (notes3_in),
        .ball_out         (ball_out),
        .left_paddle_out  (left_paddle_out),
        .right_paddle_out (right_paddle_out),
        .notes1_out       (notes1_out),
        .notes2_out       (notes2_out),
        .notes3_out       (notes3_out),
        .external_inputs  (external_inputs),
        .frame_tick       (frame_tick),
        .busy             (busy),
        .overrun_count    (overrun_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_upper(input logic [15:0] c);
`ifdef FRAME_ACK_EN
        return {1'b1, c[14:0]};
`else
        return c;
`endif
    endfunction

    task automatic push(input int unsigned tc);
        sb_t e;
        exp_frames = exp_frames + 16'd1;
        e.ball = ball_in; e.lpad = left_paddle_in; e.rpad = right_paddle_in;
        e.n1 = notes1_in; e.n2 = notes2_in; e.n3 = notes3_in;
        e.tick_cyc = tc;
        e.count = exp_frames;
        exp_q.push_back(e);
    endtask

    // Return at the negedge just before edge e.
    task automatic goto_neg(input int unsigned e);
        while (cyc < e - 1) @(negedge clock);
    endtask

    task automatic after_edge(input int unsigned e);
        goto_neg(e);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done();
        int unsigned k = 0;
        while ((busy || exp_q.size() != 0) && k < 64) begin
            @(negedge clock);
            k++;
        end
        if (k >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL service_timeout: got busy=%0b queued=%0d expected idle and empty", busy, exp_q.size());
        end
        repeat (2) @(negedge clock);
    endtask

    // Monitor: every frame_tick consumes one expected frame; the count field is checked a clock later.
    initial begin
        sb_t         e;
        logic        ext_pending;
        logic [15:0] ext_cnt;
        ext_pending = 1'b0;
        ext_cnt = '0;
        forever begin
            @(negedge clock);
            if (ext_pending) begin
                check("ext_count_field", {16'h0, external_inputs[31:16]}, {16'h0, exp_upper(ext_cnt)});
                check("ext_reserved", {22'h0, external_inputs[15:6]}, 32'h0);
                ext_pending = 1'b0;
            end
            if (!reset && frame_tick) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tick: got frame_tick=1 expected 0 (cyc %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.tick_cyc);
                    check("ball_out", ball_out, e.ball);
                    check("left_paddle_out", left_paddle_out, e.lpad);
                    check("right_paddle_out", right_paddle_out, e.rpad);
                    check("notes1_out", notes1_out, e.n1);
                    check("notes2_out", notes2_out, e.n2);
                    check("notes3_out", notes3_out, e.n3);
                    ext_cnt = e.count;
                    ext_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned k;

        reset = 1'b1; vga_vs = 1'b0; guitar_raw = 6'h3F;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'hDEAD_BEEF;
        ball_in = 32'h1111_1111; left_paddle_in = 32'h2222_2222; right_paddle_in = 32'h3333_3333;
        notes1_in = 32'h4444_4444; notes2_in = 32'h5555_5555; notes3_in = 32'h6666_6666;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ball", ball_out, 32'h0);
        check("rst_lpad", left_paddle_out, 32'h0);
        check("rst_rpad", right_paddle_out, 32'h0);
        check("rst_notes1", notes1_out, 32'h0);
        check("rst_notes2", notes2_out, 32'h0);
        check("rst_notes3", notes3_out, 32'h0);
        check("rst_ext", external_inputs, 32'h0);
        check("rst_tick", {31'h0, frame_tick}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_overrun", {24'h0, overrun_count}, 32'h0);

        @(negedge clock);
        reset = 1'b0; vga_vs = 1'b1; guitar_raw = '0;
        ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("post_rst_tick", {31'h0, frame_tick}, 32'h0);
            check("post_rst_busy", {31'h0, busy}, 32'h0);
        end

        // Clean frame: capture at N+4, tick visible right after N+4.
        @(negedge clock);
        ball_in = 32'hA5A5_0001; left_paddle_in = 32'h0000_0102; right_paddle_in = 32'h0000_0203;
        notes1_in = 32'h0F0F_0001; notes2_in = 32'h0F0F_0002; notes3_in = 32'h0F0F_0003;
        vga_vs = 1'b0;
        n = cyc + 1;
        push(n + 4);
        after_edge(n + 3);
        check("clean_ball_before_capture", ball_out, 32'h0);
        after_edge(n + 4);
        check("clean_ball_at_capture", ball_out, 32'hA5A5_0001);
        @(negedge clock);
        vga_vs = 1'b1;
        wait_done();

        // Three consecutive conflicting writes: capture on the first free clock.
        @(negedge clock);
        ball_in = 32'h0000_B002;
        vga_vs = 1'b0;
        n = cyc + 1;
        push(n + 7);
        goto_neg(n + 3);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'h1234_5678;
        goto_neg(n + 6);
        ctrl_writeEnable = 1'b0;
        vga_vs = 1'b1;
        wait_done();

        // Continuous writes: capture forced after WAIT_MAX clocks in WAIT_WR.
        @(negedge clock);
        notes2_in = 32'hC0DE_0003;
        vga_vs = 1'b0;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5;
        n = cyc + 1;
        push(n + 11);
        goto_neg(n + 12);
        ctrl_writeEnable = 1'b0;
        vga_vs = 1'b1;
        wait_done();
        check("overrun_before", {24'h0, overrun_count}, 32'h0);

        // Overrun: three falls 2 clocks apart during one stretched service.
        @(negedge clock);
        notes3_in = 32'h0BAD_0004;
        vga_vs = 1'b0;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd6;
        n = cyc + 1;
        push(n + 11);
        push(n + 15);
        goto_neg(n + 1); vga_vs = 1'b1;
        goto_neg(n + 2); vga_vs = 1'b0;
        goto_neg(n + 3); vga_vs = 1'b1;
        goto_neg(n + 4); vga_vs = 1'b0;
        goto_neg(n + 5); vga_vs = 1'b1;
        goto_neg(n + 12);
        ctrl_writeEnable = 1'b0;
        wait_done();
        check("overrun_after", {24'h0, overrun_count}, 32'h1);

        // Debounce with DB_CYCLES=4: bounce never passes, stable level lands at edge 14.
        for (int unsigned j = 0; j < 20; j++) begin
            @(negedge clock);
            guitar_raw[2] = (j < 10) ? (((j / 2) % 2) == 0) : 1'b1;
            @(posedge clock);
            #1;
            check("debounce_bit2", {31'h0, external_inputs[2]}, {31'h0, (j >= 14)});
        end

`ifdef FRAME_ACK_EN
        @(negedge clock);
        check("ack_flag_set", {31'h0, external_inputs[31]}, 32'h1);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h1;
        @(posedge clock);
        #1;
        check("ack_flag_cleared", {31'h0, external_inputs[31]}, 32'h0);
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        vga_vs = 1'b0;
        n = cyc + 1;
        push(n + 4);
        k = 0;
        while (!frame_tick && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!frame_tick) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_frame_timeout: got no frame_tick expected one within 20 clocks");
        end else begin
            ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h1;
            @(posedge clock);
            #1;
            check("ack_during_publish", {31'h0, external_inputs[31]}, 32'h1);
            @(negedge clock);
            ctrl_writeEnable = 1'b0;
        end
        vga_vs = 1'b1;
`endif

        wait_done();
        check("queue_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
